jtag_dtm_tap: RTL and testbench



---
 rtl/jtag_dtm_tap.sv | 226 ++++++++++++++++++++++
 tb/tb_jtag_dtm_tap.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dtm_tap.sv
// JTAG DTM TAP: TCK/TMS/TDI are oversampled on clk_i to run the TAP, shift IR/DR, and drive the DMI request/control outputs.
// Latency: SYNC_STAGES+1 clk from a TCK edge to the matching state change; update/reset pulses are one clk wide.
// Backpressure: none. The host paces everything through TCK, and dtm_status_i reports busy/error through DTMCS/DMI capture.
// Optional trst_n_i input under JTAG_TRST_EN: a synchronised low forces Test-Logic-Reset and IR=IDCODE.
module jtag_dtm_tap #(
    parameter logic [31:0] IDCODE      = 32'h1000_0001,
    parameter int          ABITS       = 7,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
`ifdef JTAG_TRST_EN
    input  logic             trst_n_i,
`endif
    input  logic             tck_i,
    input  logic             tms_i,
    input  logic             tdi_i,
    output logic             tdo_o,
    output logic             tdo_en_o,
    output logic [4:0]       dtm_IR_o,
    output logic [31:0]      dtm_dmi_data_o,
    output logic [ABITS-1:0] dtm_dmi_addr_o,
    output logic [1:0]       dtm_dmi_op_o,
    output logic             dtm_dmireset_o,
    output logic             dtm_dmihardreset_o,
    output logic             dtm_dr_update_o,
    input  logic [ABITS-1:0] dtm_dmi_resp_addr_i,
    input  logic [31:0]      dtm_dmi_resp_data_i,
    input  logic             dtm_status_i
);
    localparam int          DR_W      = ABITS + 34;
    localparam logic [4:0]  IR_IDCODE = 5'h01;
    localparam logic [4:0]  IR_DTMCS  = 5'h10;
    localparam logic [4:0]  IR_DMI    = 5'h11;
    localparam logic [5:0]  ABITS_FLD = 6'(ABITS);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_e;

    tap_state_e             state_q, state_d;
    logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
    logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
    logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
    logic                   tck_prev_q, tck_prev_d;
    logic [4:0]             ir_sh_q, ir_sh_d;
    logic [4:0]             ir_q, ir_d;
    logic [DR_W-1:0]        dr_q, dr_d;
    logic                   tdo_q, tdo_d;
    logic                   tdo_en_q, tdo_en_d;
    logic [31:0]            data_q, data_d;
    logic [ABITS-1:0]       addr_q, addr_d;
    logic [1:0]             op_q, op_d;
    logic                   dmireset_q, dmireset_d;
    logic                   hardreset_q, hardreset_d;
    logic                   upd_q, upd_d;
`ifdef JTAG_TRST_EN
    logic [SYNC_STAGES-1:0] trst_sync_q, trst_sync_d;
`endif

    logic tck_s, tms_s, tdi_s, tck_rise, tck_fall;

    assign tck_s    = tck_sync_q[SYNC_STAGES-1];
    assign tms_s    = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    // Next-state logic: synchronisers, TAP transitions, IR/DR capture-shift-update and TDO launch.
    always_comb begin
        tck_sync_d  = {tck_sync_q[SYNC_STAGES-2:0], tck_i};
        tms_sync_d  = {tms_sync_q[SYNC_STAGES-2:0], tms_i};
        tdi_sync_d  = {tdi_sync_q[SYNC_STAGES-2:0], tdi_i};
`ifdef JTAG_TRST_EN
        trst_sync_d = {trst_sync_q[SYNC_STAGES-2:0], trst_n_i};
`endif
        tck_prev_d  = tck_s;
        state_d     = state_q;
        ir_sh_d     = ir_sh_q;
        ir_d        = ir_q;
        dr_d        = dr_q;
        tdo_d       = tdo_q;
        data_d      = data_q;
        addr_d      = addr_q;
        op_d        = op_q;
        dmireset_d  = 1'b0;
        hardreset_d = 1'b0;
        upd_d       = 1'b0;

        if (tck_rise) begin
            case (state_q)
                TLR:     state_d = tms_s ? TLR    : RTI;
                RTI:     state_d = tms_s ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_s ? UPD_DR : PAU_DR;
                PAU_DR:  state_d = tms_s ? EX2_DR : PAU_DR;
                EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_s ? UPD_IR : PAU_IR;
                PAU_IR:  state_d = tms_s ? EX2_IR : PAU_IR;
                EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase

            case (state_q)
                CAP_IR: ir_sh_d = 5'b00001;
                SH_IR:  ir_sh_d = {tdi_s, ir_sh_q[4:1]};
                CAP_DR: begin
                    dr_d = '0;
                    case (ir_q)
                        IR_IDCODE: dr_d[31:0] = IDCODE;
                        IR_DTMCS:  dr_d[31:0] = {14'b0, 2'b00, 1'b0, 3'd1,
                                                 {2{dtm_status_i}}, ABITS_FLD, 4'd1};
                        IR_DMI:    dr_d = {dtm_dmi_resp_addr_i, dtm_dmi_resp_data_i,
                                           dtm_status_i ? 2'b11 : 2'b00};
                        default:   dr_d = '0;
                    endcase
                end
                SH_DR: begin
                    // TDI enters at the top bit of whichever register IR selects.
                    dr_d = dr_q >> 1;
                    case (ir_q)
                        IR_IDCODE, IR_DTMCS: dr_d[31]     = tdi_s;
                        IR_DMI:              dr_d[DR_W-1] = tdi_s;
                        default:             dr_d[0]      = tdi_s;
                    endcase
                end
                default: ;
            endcase

            if (state_d == UPD_DR && state_q != UPD_DR) begin
                if (ir_q == IR_DMI) begin
                    addr_d = dr_q[DR_W-1:34];
                    data_d = dr_q[33:2];
                    op_d   = dr_q[1:0];
                    upd_d  = 1'b1;
                end else if (ir_q == IR_DTMCS) begin
                    dmireset_d  = dr_q[16];
                    hardreset_d = dr_q[17];
                end
            end

            if (state_d == UPD_IR && state_q != UPD_IR) begin
                ir_d = ir_sh_q;
            end
        end

`ifdef JTAG_TRST_EN
        if (!trst_sync_q[SYNC_STAGES-1]) begin
            state_d = TLR;
        end
`endif
        if (state_d == TLR) begin
            ir_d = IR_IDCODE;
        end

        tdo_en_d = (state_d == SH_DR) || (state_d == SH_IR);
        if (!tdo_en_d) begin
            tdo_d = 1'b0;
        end else if (tck_fall) begin
            tdo_d = (state_q == SH_IR) ? ir_sh_q[0] : dr_q[0];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
`ifdef JTAG_TRST_EN
            trst_sync_q <= '0;
`endif
            tck_prev_q  <= 1'b0;
            state_q     <= TLR;
            ir_sh_q     <= '0;
            ir_q        <= IR_IDCODE;
            dr_q        <= '0;
            tdo_q       <= 1'b0;
            tdo_en_q    <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            op_q        <= '0;
            dmireset_q  <= 1'b0;
            hardreset_q <= 1'b0;
            upd_q       <= 1'b0;
        end else begin
            tck_sync_q  <= tck_sync_d;
            tms_sync_q  <= tms_sync_d;
            tdi_sync_q  <= tdi_sync_d;
`ifdef JTAG_TRST_EN
            trst_sync_q <= trst_sync_d;
`endif
            tck_prev_q  <= tck_prev_d;
            state_q     <= state_d;
            ir_sh_q     <= ir_sh_d;
            ir_q        <= ir_d;
            dr_q        <= dr_d;
            tdo_q       <= tdo_d;
            tdo_en_q    <= tdo_en_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            dmireset_q  <= dmireset_d;
            hardreset_q <= hardreset_d;
            upd_q       <= upd_d;
        end
    end

    assign tdo_o              = tdo_q;
    assign tdo_en_o           = tdo_en_q;
    assign dtm_IR_o           = ir_q;
    assign dtm_dmi_data_o     = data_q;
    assign dtm_dmi_addr_o     = addr_q;
    assign dtm_dmi_op_o       = op_q;
    assign dtm_dmireset_o     = dmireset_q;
    assign dtm_dmihardreset_o = hardreset_q;
    assign dtm_dr_update_o    = upd_q;
endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Directed bench for jtag_dtm_tap: drives TCK/TMS/TDI slowly against clk_i and checks TDO streams and DMI outputs.
// Latency: each TCK half-period spans HALF clk cycles, which leaves room for the synchroniser delay.
// Backpressure: none. Pulse outputs are counted on every clk so that pulse widths can be checked.
module tb_jtag_dtm_tap;
    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        tck_i = 1'b0;
    logic        tms_i = 1'b0;
    logic        tdi_i = 1'b0;
    logic        tdo_o;
    logic        tdo_en_o;
    logic [4:0]  dtm_IR_o;
    logic [31:0] dtm_dmi_data_o;
    logic [6:0]  dtm_dmi_addr_o;
    logic [1:0]  dtm_dmi_op_o;
    logic        dtm_dmireset_o;
    logic        dtm_dmihardreset_o;
    logic        dtm_dr_update_o;
    logic [6:0]  resp_addr = '0;
    logic [31:0] resp_data = '0;
    logic        status = 1'b0;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int rst_cnt = 0;
    int hrst_cnt = 0;
    logic [6:0] upd_addr = '0;
    logic [1:0] upd_op = '0;

    always #5 clk = ~clk;

    jtag_dtm_tap dut (
        .clk_i(clk), .reset_i(reset_i), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
        .tdo_o(tdo_o), .tdo_en_o(tdo_en_o), .dtm_IR_o(dtm_IR_o),
        .dtm_dmi_data_o(dtm_dmi_data_o), .dtm_dmi_addr_o(dtm_dmi_addr_o),
        .dtm_dmi_op_o(dtm_dmi_op_o), .dtm_dmireset_o(dtm_dmireset_o),
        .dtm_dmihardreset_o(dtm_dmihardreset_o), .dtm_dr_update_o(dtm_dr_update_o),
        .dtm_dmi_resp_addr_i(resp_addr), .dtm_dmi_resp_data_i(resp_data),
        .dtm_status_i(status)
    );

    // Count high clk cycles of each pulse output; capture the request seen during the update pulse.
    always @(posedge clk) begin
        if (dtm_dr_update_o) begin
            upd_cnt  <= upd_cnt + 1;
            upd_addr <= dtm_dmi_addr_o;
            upd_op   <= dtm_dmi_op_o;
        end
        if (dtm_dmireset_o)     rst_cnt  <= rst_cnt + 1;
        if (dtm_dmihardreset_o) hrst_cnt <= hrst_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One TCK period. TDO is sampled just before the rising edge.
    task automatic tck_cyc(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms_i = tms_v;
        tdi_i = tdi_v;
        repeat (HALF) @(negedge clk);
        tdo_v = tdo_o;
        tck_i = 1'b1;
        repeat (HALF) @(negedge clk);
        tck_i = 1'b0;
    endtask

    // Runs RTI -> Shift-IR -> Update-IR -> RTI and returns the bits shifted out.
    task automatic shift_ir(input logic [4:0] v, output logic [4:0] o);
        logic b;
        tck_cyc(1'b1, 1'b0, b);
        tck_cyc(1'b1, 1'b0, b);
        tck_cyc(1'b0, 1'b0, b);
        tck_cyc(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck_cyc(i == 4, v[i], b);
            o[i] = b;
        end
        tck_cyc(1'b1, 1'b0, b);
        tck_cyc(1'b0, 1'b0, b);
    endtask

    // Runs RTI -> Shift-DR (n bits) -> Update-DR -> RTI and returns the bits shifted out.
    task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic b;
        dout = '0;
        tck_cyc(1'b1, 1'b0, b);
        tck_cyc(1'b0, 1'b0, b);
        tck_cyc(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tck_cyc(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tck_cyc(1'b1, 1'b0, b);
        tck_cyc(1'b0, 1'b0, b);
    endtask

    initial begin
        logic [4:0]  iro;
        logic [63:0] dro;
        logic        b;
        int          saved_upd;

        // Reset state.
        repeat (5) @(negedge clk);
        chk("rst_ir", 64'(dtm_IR_o), 64'h01);
        chk("rst_data", 64'(dtm_dmi_data_o), 64'h0);
        chk("rst_addr", 64'(dtm_dmi_addr_o), 64'h0);
        chk("rst_op", 64'(dtm_dmi_op_o), 64'h0);
        chk("rst_pulses", 64'({dtm_dmireset_o, dtm_dmihardreset_o, dtm_dr_update_o}), 64'h0);
        chk("rst_tdo", 64'({tdo_o, tdo_en_o}), 64'h0);
        reset_i = 1'b1;
        repeat (3) @(negedge clk);

        // Reach TLR through TMS, go to RTI, and read IDCODE.
        for (int i = 0; i < 5; i++) tck_cyc(1'b1, 1'b0, b);
        tck_cyc(1'b0, 1'b0, b);
        shift_dr(32, 64'h0, dro);
        chk("idcode_tdo", dro, 64'h1000_0001);
        chk("idcode_ir", 64'(dtm_IR_o), 64'h01);

        // DMI write: {addr 0x10, data 1, op 2}.
        shift_ir(5'h11, iro);
        chk("ir_capture", 64'(iro), 64'h01);
        chk("ir_dmi", 64'(dtm_IR_o), 64'h11);
        shift_dr(41, {23'b0, 7'h10, 32'h0000_0001, 2'b10}, dro);
        chk("dmi_cap_idle", dro, 64'h0);
        chk("dmi_addr", 64'(dtm_dmi_addr_o), 64'h10);
        chk("dmi_data", 64'(dtm_dmi_data_o), 64'h1);
        chk("dmi_op", 64'(dtm_dmi_op_o), 64'h2);
        chk("dmi_upd_once", 64'(upd_cnt), 64'd1);
        chk("dmi_upd_coincident", 64'({upd_addr, upd_op}), 64'({7'h10, 2'b10}));

        // DMI capture of a response with sticky status; this scan writes a nop.
        resp_addr = 7'h04;
        resp_data = 32'hDEAD_BEEF;
        status    = 1'b1;
        shift_dr(41, 64'h0, dro);
        chk("dmi_resp_tdo", dro, {23'b0, 7'h04, 32'hDEAD_BEEF, 2'b11});
        chk("dmi_nop_op", 64'(dtm_dmi_op_o), 64'h0);
        chk("dmi_upd_twice", 64'(upd_cnt), 64'd2);

        // DTMCS: capture and dmireset / dmihardreset pulses.
        status = 1'b0;
        shift_ir(5'h10, iro);
        shift_dr(32, 64'h0001_0000, dro);
        chk("dtmcs_tdo", dro, 64'h0000_1071);
        chk("dmireset_pulse", 64'(rst_cnt), 64'd1);
        chk("hardreset_idle", 64'(hrst_cnt), 64'd0);
        chk("dtmcs_no_dmi_upd", 64'(upd_cnt), 64'd2);
        status = 1'b1;
        shift_dr(32, 64'h0002_0000, dro);
        chk("dtmcs_tdo_busy", dro, 64'h0000_1C71);
        chk("hardreset_pulse", 64'(hrst_cnt), 64'd1);
        chk("dmireset_still1", 64'(rst_cnt), 64'd1);
        status = 1'b0;

        // Five TMS=1 from RTI reach TLR, which restores IR to IDCODE.
        for (int i = 0; i < 5; i++) tck_cyc(1'b1, 1'b0, b);
        chk("tlr_ir", 64'(dtm_IR_o), 64'h01);
        tck_cyc(1'b0, 1'b0, b);

        // BYPASS and an unassigned code both give a one-TCK delay.
        shift_ir(5'h1F, iro);
        shift_dr(9, 64'h0A5, dro);
        chk("bypass_tdo", dro, 64'h14A);
        shift_ir(5'h05, iro);
        shift_dr(2, 64'h3, dro);
        chk("bypass_other_tdo", dro, 64'h2);

        // Reset in the middle of a DMI write scan.
        shift_ir(5'h11, iro);
        shift_dr(41, {23'b0, 7'h03, 32'h0000_0055, 2'b10}, dro);
        chk("pre_rst_op", 64'(dtm_dmi_op_o), 64'h2);
        tck_cyc(1'b1, 1'b0, b);
        tck_cyc(1'b0, 1'b0, b);
        tck_cyc(1'b0, 1'b0, b);
        for (int i = 0; i < 10; i++) tck_cyc(1'b0, 1'b1, b);
        chk("shift_tdo_en", 64'(tdo_en_o), 64'h1);
        saved_upd = upd_cnt;
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_ir", 64'(dtm_IR_o), 64'h01);
        chk("midrst_op", 64'(dtm_dmi_op_o), 64'h0);
        chk("midrst_addr", 64'(dtm_dmi_addr_o), 64'h0);
        chk("midrst_tdo", 64'({tdo_o, tdo_en_o}), 64'h0);
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        tck_cyc(1'b1, 1'b1, b);
        tck_cyc(1'b1, 1'b1, b);
        chk("midrst_no_upd", 64'(upd_cnt), 64'(saved_upd));
        tck_cyc(1'b0, 1'b0, b);
        shift_dr(32, 64'h0, dro);
        chk("post_rst_idcode", dro, 64'h1000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
